cfg_frame_loader: RTL



---
 rtl/cfg_frame_loader.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/cfg_frame_loader.sv
// Receives sync-framed configuration bytes and writes them into the channel-parameter RAM.
// Optional CFG_LOADER_CHECKSUM_EN holds back the addr-0 start byte until a trailing checksum matches.
module cfg_frame_loader #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         N_BYTES     = 113,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] w_addr,
  output logic [7:0] wr_data,
  output logic       write,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_err
);

  localparam int AW = $clog2(N_BYTES);
  localparam int TW = $clog2(TIMEOUT_CYC);

`ifdef CFG_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, PAYLOAD} state_t;
`endif

  state_t          state, state_n;
  logic [AW-1:0]   addr_cnt, addr_cnt_n;
  logic [TW-1:0]   idle_cnt, idle_cnt_n;
  logic [7:0]      w_addr_n, wr_data_n;
  logic            write_n, frame_done_n, frame_err_n;
  logic            timeout_hit;

`ifdef CFG_LOADER_CHECKSUM_EN
  logic [7:0]      sum, sum_n;
  logic [7:0]      held, held_n;
`endif

  assign timeout_hit = (idle_cnt == TW'(TIMEOUT_CYC - 1));
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_cnt   <= '0;
      idle_cnt   <= '0;
      w_addr     <= '0;
      wr_data    <= '0;
      write      <= 1'b1;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
`ifdef CFG_LOADER_CHECKSUM_EN
      sum        <= '0;
      held       <= '0;
`endif
    end else begin
      state      <= state_n;
      addr_cnt   <= addr_cnt_n;
      idle_cnt   <= idle_cnt_n;
      w_addr     <= w_addr_n;
      wr_data    <= wr_data_n;
      write      <= write_n;
      frame_done <= frame_done_n;
      frame_err  <= frame_err_n;
`ifdef CFG_LOADER_CHECKSUM_EN
      sum        <= sum_n;
      held       <= held_n;
`endif
    end
  end

  // A byte arriving in the expiry cycle takes priority over the timeout.
  always_comb begin
    state_n      = state;
    addr_cnt_n   = addr_cnt;
    idle_cnt_n   = idle_cnt;
    w_addr_n     = w_addr;
    wr_data_n    = wr_data;
    write_n      = 1'b1;
    frame_done_n = 1'b0;
    frame_err_n  = frame_err;
`ifdef CFG_LOADER_CHECKSUM_EN
    sum_n        = sum;
    held_n       = held;
`endif

    case (state)
      IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_n     = PAYLOAD;
          addr_cnt_n  = AW'(N_BYTES - 1);
          idle_cnt_n  = '0;
          frame_err_n = 1'b0;
`ifdef CFG_LOADER_CHECKSUM_EN
          sum_n       = '0;
`endif
        end
      end

      PAYLOAD: begin
        if (rx_valid) begin
          idle_cnt_n = '0;
          addr_cnt_n = addr_cnt - 1'b1;
`ifdef CFG_LOADER_CHECKSUM_EN
          sum_n      = sum + rx_data;
`endif
          if (addr_cnt == '0) begin
`ifdef CFG_LOADER_CHECKSUM_EN
            held_n       = rx_data;
            state_n      = CHECK;
`else
            w_addr_n     = 8'd0;
            wr_data_n    = rx_data;
            write_n      = 1'b0;
            frame_done_n = 1'b1;
            state_n      = IDLE;
`endif
          end else begin
            w_addr_n  = 8'(addr_cnt);
            wr_data_n = rx_data;
            write_n   = 1'b0;
          end
        end else if (timeout_hit) begin
          state_n     = IDLE;
          frame_err_n = 1'b1;
        end else begin
          idle_cnt_n = idle_cnt + 1'b1;
        end
      end

`ifdef CFG_LOADER_CHECKSUM_EN
      // The start command only reaches the RAM if the whole frame summed correctly.
      CHECK: begin
        if (rx_valid) begin
          idle_cnt_n = '0;
          state_n    = IDLE;
          if (rx_data == sum) begin
            w_addr_n     = 8'd0;
            wr_data_n    = held;
            write_n      = 1'b0;
            frame_done_n = 1'b1;
          end else begin
            frame_err_n = 1'b1;
          end
        end else if (timeout_hit) begin
          state_n     = IDLE;
          frame_err_n = 1'b1;
        end else begin
          idle_cnt_n = idle_cnt + 1'b1;
        end
      end
`endif

      default: state_n = IDLE;
    endcase
  end

endmodule
